// File: rtl/fu_share_pkg.sv
// fu_share_pkg: shared types and constants for the shared-FU arbiter.
// Holds the one-hot state encoding, FU opcodes and the pointer width helper.
package fu_share_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_ISSUE = 4'b0010,
        ST_WAIT  = 4'b0100,
        ST_RESP  = 4'b1000
    } state_t;

    localparam logic [1:0] OP_SUB  = 2'd0;
    localparam logic [1:0] OP_CMP  = 2'd1;
    localparam logic [1:0] OP_MOD  = 2'd2;
    localparam logic [1:0] OP_PASS = 2'd3;

    // Width of a requester index; never below one bit.
    function automatic int ptr_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fu_share_arb_rr_pick.sv
// rr_pick: combinational round-robin picker.
// Ports: req (request levels), ptr (priority start) -> win (one-hot), idx.
module rr_pick
    import fu_share_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int PTRW = ptr_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PTRW-1:0] ptr,
    output logic [NREQ-1:0] win,
    output logic [PTRW-1:0] idx
);

    logic found;

    // Scan from ptr upward, wrapping, and keep the first set bit.
    always_comb begin : pick
        int j;
        win   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!found && req[j]) begin
                found  = 1'b1;
                win[j] = 1'b1;
                idx    = j[PTRW-1:0];
            end
        end
    end

endmodule

// File: rtl/fu_share_arb.sv
// fu_share_arb: round-robin sharing of one multi-cycle FU among NREQ kernels.
// Ports: req/req_op/req_a/req_b in, gnt/fu_* issue, fu_done/fu_result back,
//   rsp_valid/rsp_data out, ap_idle status. With FU_SHARE_ARB_TIMEOUT_EN a
//   watchdog aborts WAIT after TIMEOUT cycles and pulses rsp_err.
module fu_share_arb
    import fu_share_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int DW      = 32,
    parameter int OPW     = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                ap_clk,
    input  logic                ap_rst_n,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*OPW-1:0] req_op,
    input  logic [NREQ*DW-1:0]  req_a,
    input  logic [NREQ*DW-1:0]  req_b,
    output logic [NREQ-1:0]     gnt,
    output logic                fu_start,
    output logic [OPW-1:0]      fu_op,
    output logic [DW-1:0]       fu_a,
    output logic [DW-1:0]       fu_b,
    input  logic                fu_done,
    input  logic [DW-1:0]       fu_result,
    output logic [NREQ-1:0]     rsp_valid,
    output logic [DW-1:0]       rsp_data,
`ifdef FU_SHARE_ARB_TIMEOUT_EN
    output logic                rsp_err,
`endif
    output logic                ap_idle
);

    localparam int PTRW = ptr_w(NREQ);

    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_bad_cfg
        $error("fu_share_arb: NREQ must be 2..8, TIMEOUT >= 1");
    end

    state_t          state;
    logic [PTRW-1:0] ptr;
    logic [PTRW-1:0] wi;
    logic [NREQ-1:0] wsel;
    logic [NREQ-1:0] pick_win;
    logic [PTRW-1:0] pick_idx;

`ifdef FU_SHARE_ARB_TIMEOUT_EN
    localparam int TOW = $clog2(TIMEOUT + 1);
    logic [TOW-1:0] wdog;
`endif

    rr_pick #(
        .NREQ (NREQ),
        .PTRW (PTRW)
    ) u_pick (
        .req (req),
        .ptr (ptr),
        .win (pick_win),
        .idx (pick_idx)
    );

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            wi        <= '0;
            wsel      <= '0;
            gnt       <= '0;
            fu_start  <= 1'b0;
            fu_op     <= '0;
            fu_a      <= '0;
            fu_b      <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            ap_idle   <= 1'b1;
`ifdef FU_SHARE_ARB_TIMEOUT_EN
            wdog      <= '0;
            rsp_err   <= 1'b0;
`endif
        end else begin
            ap_idle <= (state == ST_IDLE) && (req == '0);
            case (state)
                ST_IDLE: begin
                    if (req != '0) begin
                        wi       <= pick_idx;
                        wsel     <= pick_win;
                        fu_op    <= req_op[pick_idx*OPW +: OPW];
                        fu_a     <= req_a[pick_idx*DW +: DW];
                        fu_b     <= req_b[pick_idx*DW +: DW];
                        gnt      <= pick_win;
                        fu_start <= 1'b1;
                        state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    gnt      <= '0;
                    fu_start <= 1'b0;
                    state    <= ST_WAIT;
`ifdef FU_SHARE_ARB_TIMEOUT_EN
                    wdog     <= '0;
`endif
                end
                ST_WAIT: begin
                    if (fu_done) begin
                        rsp_data  <= fu_result;
                        rsp_valid <= wsel;
                        state     <= ST_RESP;
`ifdef FU_SHARE_ARB_TIMEOUT_EN
                    end else if (wdog == TOW'(TIMEOUT - 1)) begin
                        // FU never answered: return an error marker.
                        rsp_data  <= '1;
                        rsp_valid <= wsel;
                        rsp_err   <= 1'b1;
                        state     <= ST_RESP;
                    end else begin
                        wdog <= wdog + 1'b1;
`endif
                    end
                end
                ST_RESP: begin
                    rsp_valid <= '0;
                    ptr       <= (wi == PTRW'(NREQ - 1)) ? '0 : wi + 1'b1;
                    state     <= ST_IDLE;
`ifdef FU_SHARE_ARB_TIMEOUT_EN
                    rsp_err   <= 1'b0;
`endif
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fu_share_arb.sv
// tb_fu_share_arb: scoreboard bench for fu_share_arb with a latency-3 FU model.
// Covers reset, single issue, round-robin order, wrap, stray done, mid reset.
module tb_fu_share_arb;
    import fu_share_pkg::*;

    localparam int NREQ = 4;
    localparam int DW   = 32;
    localparam int OPW  = 2;
`ifdef FU_SHARE_ARB_TIMEOUT_EN
    localparam int TIMEOUT = 8;
`else
    localparam int TIMEOUT = 64;
`endif

    logic                ap_clk;
    logic                ap_rst_n;
    logic [NREQ-1:0]     req;
    logic [NREQ*OPW-1:0] req_op;
    logic [NREQ*DW-1:0]  req_a;
    logic [NREQ*DW-1:0]  req_b;
    logic [NREQ-1:0]     gnt;
    logic                fu_start;
    logic [OPW-1:0]      fu_op;
    logic [DW-1:0]       fu_a;
    logic [DW-1:0]       fu_b;
    logic                fu_done;
    logic [DW-1:0]       fu_result;
    logic [NREQ-1:0]     rsp_valid;
    logic [DW-1:0]       rsp_data;
    logic                ap_idle;
`ifdef FU_SHARE_ARB_TIMEOUT_EN
    logic                rsp_err;
`endif

    logic [OPW-1:0] op_v [NREQ];
    logic [DW-1:0]  a_v  [NREQ];
    logic [DW-1:0]  b_v  [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_pack
        assign req_op[g*OPW +: OPW] = op_v[g];
        assign req_a[g*DW +: DW]    = a_v[g];
        assign req_b[g*DW +: DW]    = b_v[g];
    end

    logic          model_done;
    logic          man_done;
    logic [DW-1:0] model_res;
    logic [DW-1:0] man_res;
    bit            fu_en;

    assign fu_done   = model_done | man_done;
    assign fu_result = man_done ? man_res : model_res;

    typedef struct {
        int            idx;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sb[$];
    int            checks;
    int            failures;
    logic [DW-1:0] last_data;

    fu_share_arb #(
        .NREQ    (NREQ),
        .DW      (DW),
        .OPW     (OPW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .req       (req),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .gnt       (gnt),
        .fu_start  (fu_start),
        .fu_op     (fu_op),
        .fu_a      (fu_a),
        .fu_b      (fu_b),
        .fu_done   (fu_done),
        .fu_result (fu_result),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
`ifdef FU_SHARE_ARB_TIMEOUT_EN
        .rsp_err   (rsp_err),
`endif
        .ap_idle   (ap_idle)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    function automatic logic [DW-1:0] fu_calc(input logic [OPW-1:0] op,
                                              input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
        case (op)
            OP_SUB:  return a - b;
            OP_CMP:  return (a < b) ? 1 : 0;
            OP_MOD:  return (b == 0) ? a : a % b;
            default: return a;
        endcase
    endfunction

    // External FU: result three negedges after it sees fu_start.
    initial begin : fu_model
        logic [DW-1:0] r;
        model_done = 1'b0;
        model_res  = '0;
        forever begin
            @(negedge ap_clk);
            if (fu_en && fu_start === 1'b1) begin
                r = fu_calc(fu_op, fu_a, fu_b);
                repeat (3) @(negedge ap_clk);
                model_res  = r;
                model_done = 1'b1;
                @(negedge ap_clk);
                model_done = 1'b0;
            end
        end
    end

    task automatic wait_gnt(output logic [NREQ-1:0] g, output int lat,
                            output bit ok);
        ok  = 1'b0;
        g   = '0;
        lat = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge ap_clk);
            if (gnt != '0) begin
                g   = gnt;
                lat = c + 1;
                ok  = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_rsp(output int lat, output bit ok);
        ok  = 1'b0;
        lat = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge ap_clk);
            if (rsp_valid != '0) begin
                lat = c + 1;
                ok  = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        ap_rst_n = 1'b0;
        req      = '0;
        repeat (3) @(negedge ap_clk);
        checks += 8;
        if (gnt !== '0) begin
            failures++; $display("FAIL rst_gnt got=%b exp=0", gnt);
        end
        if (fu_start !== 1'b0) begin
            failures++; $display("FAIL rst_fu_start got=%b exp=0", fu_start);
        end
        if (rsp_valid !== '0) begin
            failures++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid);
        end
        if (fu_op !== '0) begin
            failures++; $display("FAIL rst_fu_op got=%0d exp=0", fu_op);
        end
        if (fu_a !== '0) begin
            failures++; $display("FAIL rst_fu_a got=%h exp=0", fu_a);
        end
        if (fu_b !== '0) begin
            failures++; $display("FAIL rst_fu_b got=%h exp=0", fu_b);
        end
        if (rsp_data !== '0) begin
            failures++; $display("FAIL rst_rsp_data got=%h exp=0", rsp_data);
        end
        if (ap_idle !== 1'b1) begin
            failures++; $display("FAIL rst_ap_idle got=%b exp=1", ap_idle);
        end
        ap_rst_n = 1'b1;
        repeat (2) @(negedge ap_clk);
        checks++;
        if (ap_idle !== 1'b1) begin
            failures++; $display("FAIL post_rst_idle got=%b exp=1", ap_idle);
        end
        last_data = '0;
    endtask

    task automatic test_single();
        logic [NREQ-1:0] g;
        int              lat;
        bit              ok;
        exp_t            e;
        req = 4'b0001;
        wait_gnt(g, lat, ok);
        checks += 6;
        if (!ok || g !== 4'b0001 || lat != 1) begin
            failures++;
            $display("FAIL single_gnt got=%b lat=%0d exp=0001 lat=1", g, lat);
        end
        if (fu_start !== 1'b1) begin
            failures++; $display("FAIL single_fu_start got=%b exp=1", fu_start);
        end
        if (fu_op !== OP_SUB) begin
            failures++; $display("FAIL single_fu_op got=%0d exp=0", fu_op);
        end
        if (fu_a !== 32'd48) begin
            failures++; $display("FAIL single_fu_a got=%0d exp=48", fu_a);
        end
        if (fu_b !== 32'd18) begin
            failures++; $display("FAIL single_fu_b got=%0d exp=18", fu_b);
        end
        if (ap_idle !== 1'b0) begin
            failures++; $display("FAIL single_busy got=%b exp=0", ap_idle);
        end
        req = '0;
        sb.push_back('{idx: 0, data: 32'd30});
        wait_rsp(lat, ok);
        e = sb.pop_front();
        checks += 3;
        if (!ok || lat != 4) begin
            failures++; $display("FAIL single_lat got=%0d exp=4", lat);
        end
        if (rsp_valid !== NREQ'(1) << e.idx) begin
            failures++; $display("FAIL single_rsp_v got=%b exp=0001", rsp_valid);
        end
        if (rsp_data !== e.data) begin
            failures++;
            $display("FAIL single_rsp_d got=%0d exp=%0d", rsp_data, e.data);
        end
        last_data = e.data;
        repeat (2) @(negedge ap_clk);
        checks++;
        if (ap_idle !== 1'b1) begin
            failures++; $display("FAIL single_idle got=%b exp=1", ap_idle);
        end
    endtask

    task automatic test_stray_done();
        bit seen;
        man_res  = 32'hDEAD;
        man_done = 1'b1;
        @(negedge ap_clk);
        man_done = 1'b0;
        seen     = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge ap_clk);
            if (rsp_valid != '0) seen = 1'b1;
        end
        checks += 2;
        if (seen) begin
            failures++; $display("FAIL stray_rsp got=1 exp=0");
        end
        if (rsp_data !== last_data) begin
            failures++;
            $display("FAIL stray_data got=%h exp=%h", rsp_data, last_data);
        end
    endtask

    task automatic test_rr_all();
        int   ngr;
        int   nrsp;
        int   w;
        exp_t e;
        ap_rst_n = 1'b0;
        req      = 4'b1111;
        repeat (2) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        ngr  = 0;
        nrsp = 0;
        for (int c = 0; c < 200 && nrsp < 5; c++) begin
            @(negedge ap_clk);
            if (gnt != '0) begin
                w = ngr % NREQ;
                checks++;
                if (gnt !== NREQ'(1) << w) begin
                    failures++;
                    $display("FAIL rr_gnt%0d got=%b exp_idx=%0d", ngr, gnt, w);
                end
                sb.push_back('{idx: w, data: fu_calc(op_v[w], a_v[w], b_v[w])});
                ngr++;
            end
            if (rsp_valid != '0) begin
                e = sb.pop_front();
                checks++;
                if (rsp_valid !== NREQ'(1) << e.idx || rsp_data !== e.data) begin
                    failures++;
                    $display("FAIL rr_rsp%0d got=%b/%h exp_idx=%0d/%h",
                             nrsp, rsp_valid, rsp_data, e.idx, e.data);
                end
                last_data = e.data;
                nrsp++;
                if (nrsp == 5) req = '0;
            end
        end
        checks++;
        if (nrsp != 5) begin
            failures++; $display("FAIL rr_timeout got=%0d exp=5", nrsp);
        end
        sb.delete();
        repeat (3) @(negedge ap_clk);
    endtask

    task automatic test_wrap();
        logic [NREQ-1:0] masks [4];
        int              wins  [4];
        logic [NREQ-1:0] g;
        int              lat;
        bit              ok;
        exp_t            e;
        masks = '{4'b1000, 4'b1001, 4'b1001, 4'b0010};
        wins  = '{3, 0, 3, 1};
        for (int i = 0; i < 4; i++) begin
            req = masks[i];
            wait_gnt(g, lat, ok);
            checks++;
            if (!ok || g !== NREQ'(1) << wins[i]) begin
                failures++;
                $display("FAIL wrap_gnt%0d got=%b exp_idx=%0d", i, g, wins[i]);
            end
            req = '0;
            sb.push_back('{idx: wins[i],
                           data: fu_calc(op_v[wins[i]], a_v[wins[i]],
                                         b_v[wins[i]])});
            wait_rsp(lat, ok);
            e = sb.pop_front();
            checks += 2;
            if (!ok || rsp_valid !== NREQ'(1) << e.idx) begin
                failures++;
                $display("FAIL wrap_rsp_v%0d got=%b exp_idx=%0d",
                         i, rsp_valid, e.idx);
            end
            if (rsp_data !== e.data) begin
                failures++;
                $display("FAIL wrap_rsp_d%0d got=%h exp=%h", i, rsp_data, e.data);
            end
            last_data = e.data;
            @(negedge ap_clk);
        end
    endtask

    task automatic test_reset_mid();
        logic [NREQ-1:0] g;
        int              lat;
        bit              ok;
        bit              seen;
        exp_t            e;
        req = 4'b0100;
        wait_gnt(g, lat, ok);
        checks++;
        if (!ok || g !== 4'b0100) begin
            failures++; $display("FAIL mid_gnt got=%b exp=0100", g);
        end
        req = '0;
        @(negedge ap_clk);
        ap_rst_n = 1'b0;
        @(negedge ap_clk);
        ap_rst_n  = 1'b1;
        last_data = '0;
        seen      = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge ap_clk);
            if (rsp_valid != '0) seen = 1'b1;
        end
        checks += 3;
        if (seen) begin
            failures++; $display("FAIL mid_late_rsp got=1 exp=0");
        end
        if (ap_idle !== 1'b1) begin
            failures++; $display("FAIL mid_idle got=%b exp=1", ap_idle);
        end
        if (rsp_data !== last_data) begin
            failures++; $display("FAIL mid_data got=%h exp=0", rsp_data);
        end
        req = 4'b0101;
        wait_gnt(g, lat, ok);
        checks++;
        if (!ok || g !== 4'b0001) begin
            failures++; $display("FAIL mid_ptr0 got=%b exp=0001", g);
        end
        req = '0;
        sb.push_back('{idx: 0, data: fu_calc(op_v[0], a_v[0], b_v[0])});
        wait_rsp(lat, ok);
        e = sb.pop_front();
        checks++;
        if (!ok || rsp_valid !== NREQ'(1) << e.idx || rsp_data !== e.data) begin
            failures++;
            $display("FAIL mid_rsp got=%b/%h exp_idx=%0d/%h",
                     rsp_valid, rsp_data, e.idx, e.data);
        end
        repeat (3) @(negedge ap_clk);
    endtask

`ifdef FU_SHARE_ARB_TIMEOUT_EN
    task automatic test_timeout();
        logic [NREQ-1:0] g;
        int              lat;
        bit              ok;
        fu_en = 1'b0;
        req   = 4'b0001;
        wait_gnt(g, lat, ok);
        req = '0;
        wait_rsp(lat, ok);
        checks += 4;
        if (!ok || lat != 9) begin
            failures++; $display("FAIL to_lat got=%0d exp=9", lat);
        end
        if (rsp_valid !== 4'b0001) begin
            failures++; $display("FAIL to_rsp_v got=%b exp=0001", rsp_valid);
        end
        if (rsp_err !== 1'b1) begin
            failures++; $display("FAIL to_err got=%b exp=1", rsp_err);
        end
        if (rsp_data !== 32'hFFFF_FFFF) begin
            failures++; $display("FAIL to_data got=%h exp=ffffffff", rsp_data);
        end
        @(negedge ap_clk);
        checks++;
        if (rsp_err !== 1'b0) begin
            failures++; $display("FAIL to_err_clr got=%b exp=0", rsp_err);
        end
        fu_en = 1'b1;
        repeat (2) @(negedge ap_clk);
    endtask
`endif

    initial begin
        checks    = 0;
        failures  = 0;
        last_data = '0;
        ap_rst_n  = 1'b0;
        req       = '0;
        man_done  = 1'b0;
        man_res   = '0;
        fu_en     = 1'b1;
        op_v[0] = OP_SUB;  a_v[0] = 32'd48;     b_v[0] = 32'd18;
        op_v[1] = OP_CMP;  a_v[1] = 32'd5;      b_v[1] = 32'd9;
        op_v[2] = OP_MOD;  a_v[2] = 32'd100;    b_v[2] = 32'd7;
        op_v[3] = OP_PASS; a_v[3] = 32'h1234;   b_v[3] = 32'd0;
        test_reset();
        test_single();
        test_stray_done();
        test_rr_all();
        test_wrap();
        test_reset_mid();
`ifdef FU_SHARE_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
